wb_arbiter_2x1: RTL

WB_ARBITER_2X1 -- requirements
Module: wb_arbiter_2x1

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_if.sv | 25 ++
 rtl/wb_outstanding_cnt.sv | 52 +++++
 rtl/wb_arbiter_2x1.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, GNT0, GNT1)
//   WB_ARB_CNT_W : width of the outstanding-request counter
package wb_arb_pkg;

  localparam int WB_ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone B4 bundle.
//   master modport : drives cyc/stb/we/sel/adr/dat_m2s, receives dat_s2m/ack/err/stall
//   slave  modport : the mirror image
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m2s,
    input  dat_s2m, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m2s,
    output dat_s2m, ack, err, stall
  );
endinterface

// File: rtl/wb_outstanding_cnt.sv
// Outstanding-request counter for the arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : a request was accepted by the target this cycle
//   dec      : a response (ack or err) arrived this cycle
//   clr      : grant is being released; drop everything in flight
//   limit    : maximum number of requests allowed in flight
//   count    : current number of requests in flight
//   full     : count has reached limit
module wb_outstanding_cnt
  import wb_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  input  logic [WB_ARB_CNT_W-1:0] limit,
  output logic [WB_ARB_CNT_W-1:0] count,
  output logic                    full
);

  logic [WB_ARB_CNT_W-1:0] count_reg;
  logic [WB_ARB_CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && !dec) begin
      if (count_reg != '1) begin
        count_next = count_reg + 1'b1;
      end
    end else if (dec && !inc) begin
      // A stray response with nothing in flight must not wrap the counter.
      if (count_reg != '0) begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg >= limit);

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-to-one pipelined Wishbone B4 arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   m0       : requester 0 (instruction side), slave modport
//   m1       : requester 1 (data side), slave modport
//   s        : shared target, master modport
// Parameter MAX_OUTSTANDING (1..15) bounds accepted-but-unanswered requests
// per grant. Define WB_ARB_ROUND_ROBIN_EN to resolve simultaneous requests in
// favour of the master not granted last; otherwise m1 always wins.
module wb_arbiter_2x1
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s
);

  localparam logic [WB_ARB_CNT_W-1:0] LIMIT = WB_ARB_CNT_W'(MAX_OUTSTANDING);

  arb_state_t state_reg;
  arb_state_t state_next;

  logic                    pick1;
  logic                    inc;
  logic                    dec;
  logic                    clr;
  logic                    full;
  logic [WB_ARB_CNT_W-1:0] count;

  logic        s_cyc;
  logic        s_stb;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr;
  logic [31:0] s_dat;
  logic        m0_stall;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_dat;
  logic        m1_stall;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_dat;

  // Tie-break when both masters request in the same IDLE cycle.
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_reg;  // 1 = m1 was granted most recently

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b0;
    end else if (state_reg == IDLE && state_next == GNT0) begin
      last_reg <= 1'b0;
    end else if (state_reg == IDLE && state_next == GNT1) begin
      last_reg <= 1'b1;
    end
  end

  assign pick1 = ~last_reg;
`else
  assign pick1 = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grants never hand over directly; dropping cyc always goes through IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_next = pick1 ? GNT1 : GNT0;
        end else if (m0.cyc) begin
          state_next = GNT0;
        end else if (m1.cyc) begin
          state_next = GNT1;
        end
      end
      GNT0: if (!m0.cyc) state_next = IDLE;
      GNT1: if (!m1.cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus steering. Anything not granted sees a stalled, silent bus, which
  // also discards responses that straggle in while IDLE.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_adr    = '0;
    s_dat    = '0;
    m0_stall = 1'b1;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat   = '0;
    m1_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat   = '0;
    case (state_reg)
      GNT0: begin
        s_cyc    = m0.cyc;
        s_stb    = m0.cyc & m0.stb & ~full;
        s_we     = m0.we;
        s_sel    = m0.sel;
        s_adr    = m0.adr;
        s_dat    = m0.dat_m2s;
        m0_stall = s.stall | full;
        m0_ack   = s.ack;
        m0_err   = s.err;
        m0_dat   = s.dat_s2m;
      end
      GNT1: begin
        s_cyc    = m1.cyc;
        s_stb    = m1.cyc & m1.stb & ~full;
        s_we     = m1.we;
        s_sel    = m1.sel;
        s_adr    = m1.adr;
        s_dat    = m1.dat_m2s;
        m1_stall = s.stall | full;
        m1_ack   = s.ack;
        m1_err   = s.err;
        m1_dat   = s.dat_s2m;
      end
      default: ;
    endcase
  end

  assign inc = s_stb & ~s.stall;
  assign dec = (state_reg != IDLE) & (s.ack | s.err);
  // Dropping cyc aborts the cycle: anything still in flight is forgotten.
  assign clr = ((state_reg == GNT0) && !m0.cyc) || ((state_reg == GNT1) && !m1.cyc);

  wb_outstanding_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .limit (LIMIT),
    .count (count),
    .full  (full)
  );

  assign s.cyc      = s_cyc;
  assign s.stb      = s_stb;
  assign s.we       = s_we;
  assign s.sel      = s_sel;
  assign s.adr      = s_adr;
  assign s.dat_m2s  = s_dat;
  assign m0.stall   = m0_stall;
  assign m0.ack     = m0_ack;
  assign m0.err     = m0_err;
  assign m0.dat_s2m = m0_dat;
  assign m1.stall   = m1_stall;
  assign m1.ack     = m1_ack;
  assign m1.err     = m1_err;
  assign m1.dat_s2m = m1_dat;

endmodule
